// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, ALU operation
// codes (also used by the ALU), operand/PC select codes and instruction fields.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;
  localparam logic [1:0] SRCB_LUI  = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_IMM = 3'd1,
    CL_LW  = 3'd2,
    CL_SW  = 3'd3,
    CL_BR  = 3'd4,
    CL_J   = 3'd5
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic       bne;
    logic [2:0] alu_op;
    logic [1:0] alu_srcb;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: class, ALU operation, B-operand select
// and legality from the opcode and funct fields.
module mc_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec.cls      = CL_R;
    dec.bne      = 1'b0;
    dec.alu_op   = ALU_ADD;
    dec.alu_srcb = SRCB_REG;
    dec.legal    = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          default: dec.legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.cls = CL_IMM; dec.alu_srcb = SRCB_SEXT; end
      OP_ANDI: begin dec.cls = CL_IMM; dec.alu_op = ALU_AND;   dec.alu_srcb = SRCB_ZEXT; end
      OP_ORI:  begin dec.cls = CL_IMM; dec.alu_op = ALU_OR;    dec.alu_srcb = SRCB_ZEXT; end
      OP_XORI: begin dec.cls = CL_IMM; dec.alu_op = ALU_XOR;   dec.alu_srcb = SRCB_ZEXT; end
      OP_LUI:  begin dec.cls = CL_IMM; dec.alu_op = ALU_PASSB; dec.alu_srcb = SRCB_LUI;  end
      OP_LW:   begin dec.cls = CL_LW;  dec.alu_srcb = SRCB_SEXT; end
      OP_SW:   begin dec.cls = CL_SW;  dec.alu_srcb = SRCB_SEXT; end
      OP_BEQ:  begin dec.cls = CL_BR;  dec.alu_op = ALU_SUB; end
      OP_BNE:  begin dec.cls = CL_BR;  dec.alu_op = ALU_SUB; dec.bne = 1'b1; end
      OP_J:    dec.cls   = CL_J;
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EX/MEM/WB). Outputs are decoded from the
// current state and instruction; only alu_op remembers its last EX value.
module mc_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        iord,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  alu_srcb,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state
);

  // Memory handshake: mem_re/mem_we is the request and stays high while the
  // FSM waits in IF or MEM; the access completes in the cycle mem_rdy is high,
  // and mem_rdy is ignored in every other state.

  state_e     state_q, state_d;
  logic [2:0] alu_op_q;
  dec_t       dec;

  mc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      alu_op_q <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == S_EX) alu_op_q <= dec.alu_op;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srcb   = SRCB_REG;
    alu_op     = alu_op_q;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_re = 1'b1;
        if (mem_rdy) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (!dec.legal) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else if (dec.cls == CL_J) begin
          pc_we   = 1'b1;
          pc_src  = PC_JMP;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_op   = dec.alu_op;
        alu_srcb = dec.alu_srcb;
        case (dec.cls)
          CL_LW, CL_SW: state_d = S_MEM;
          CL_BR: begin
            // beq takes the branch on zero, bne on not-zero.
            if (zero ^ dec.bne) begin
              pc_we  = 1'b1;
              pc_src = PC_BR;
            end
            state_d = S_IF;
          end
          CL_R, CL_IMM: state_d = S_WB;
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_re = (dec.cls == CL_LW);
        mem_we = (dec.cls == CL_SW);
        if (mem_rdy) state_d = (dec.cls == CL_LW) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (dec.cls == CL_R);
        mem_to_reg = (dec.cls == CL_LW);
        state_d    = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // Reset abandons any access in flight: every request drops immediately.
    if (!rst_n) begin
      pc_we      = 1'b0;
      pc_src     = PC_PLUS4;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_srcb   = SRCB_REG;
      alu_op     = ALU_ADD;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-timeline model builds the expected output
// vector for every cycle; directed scenarios add literal spot checks.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_rdy;
  logic        pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg, illegal;
  logic [1:0]  pc_src, alu_srcb;
  logic [2:0]  alu_op, state;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .iord       (iord),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] srcb;
    logic [2:0] aop;
    logic       ill;
  } rec_t;

  localparam int W = $bits(rec_t);

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_AND  = 32'h00221824;
  localparam logic [31:0] I_OR   = 32'h00221825;
  localparam logic [31:0] I_XOR  = 32'h00221826;
  localparam logic [31:0] I_BADF = 32'h00221821;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_ANDI = 32'h30220F0F;
  localparam logic [31:0] I_ORI  = 32'h34220F0F;
  localparam logic [31:0] I_XORI = 32'h38220F0F;
  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_BADO = 32'hFC000000;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] cmp_e;
  rec_t         act;
  logic [2:0]   last_aop;
  int           errors = 0;
  int           checks = 0;

  assign act = {state, pc_we, pc_src, ir_we, iord, mem_re, mem_we, reg_we, reg_dst,
                mem_to_reg, alu_srcb, alu_op, illegal};

  // Compare process: every cycle that has an expectation is checked mid-cycle.
  always @(negedge clk) begin
    hist.push_back(act);
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (act !== cmp_e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got=%b exp=%b (st pcwe pcsrc irwe iord re we regwe dst m2r srcb aop ill)",
                 $time, act, cmp_e);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction table: class 0 R, 1 imm, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 illegal.
  task automatic ref_dec(input logic [31:0] ins, output int cls, output logic [2:0] a,
                         output logic [1:0] sb);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    cls = 7; a = 3'b000; sb = 2'b00;
    if (op == 6'h00) begin
      cls = 0;
      if      (fn == 6'h20) a = 3'b000;
      else if (fn == 6'h22) a = 3'b100;
      else if (fn == 6'h24) a = 3'b001;
      else if (fn == 6'h25) a = 3'b101;
      else if (fn == 6'h26) a = 3'b010;
      else cls = 7;
    end
    else if (op == 6'h08) begin cls = 1; a = 3'b000; sb = 2'b01; end
    else if (op == 6'h0C) begin cls = 1; a = 3'b001; sb = 2'b10; end
    else if (op == 6'h0D) begin cls = 1; a = 3'b101; sb = 2'b10; end
    else if (op == 6'h0E) begin cls = 1; a = 3'b010; sb = 2'b10; end
    else if (op == 6'h0F) begin cls = 1; a = 3'b110; sb = 2'b11; end
    else if (op == 6'h23) begin cls = 2; a = 3'b000; sb = 2'b01; end
    else if (op == 6'h2B) begin cls = 3; a = 3'b000; sb = 2'b01; end
    else if (op == 6'h04) begin cls = 4; a = 3'b100; end
    else if (op == 6'h05) begin cls = 5; a = 3'b100; end
    else if (op == 6'h02) cls = 6;
  endtask

  function automatic rec_t base(input logic [2:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    r.aop = last_aop;
    return r;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic z, input logic [31:0] ins,
                      input rec_t r);
    @(posedge clk);
    #1;
    rst_n = rst; mem_rdy = rdy; zero = z; instr = ins;
    exp_q.push_back(r);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // Expected timeline of one instruction: stalls, IF, ID, then class-dependent tail.
  task automatic run_instr(input logic [31:0] ins, input int if_wait, input int mem_wait,
                           input logic z, input bit abort_mem);
    int         cls;
    logic [2:0] a;
    logic [1:0] sb;
    rec_t       r;
    ref_dec(ins, cls, a, sb);
    for (int i = 0; i < if_wait; i++) begin
      r = base(3'd0); r.mem_re = 1'b1;
      step(1'b1, 1'b0, rb(), ins, r);
    end
    r = base(3'd0); r.mem_re = 1'b1; r.ir_we = 1'b1; r.pc_we = 1'b1;
    step(1'b1, 1'b1, rb(), ins, r);
    r = base(3'd1);
    if (cls == 6) begin r.pc_we = 1'b1; r.pc_src = 2'b10; end
    if (cls == 7) r.ill = 1'b1;
    step(1'b1, rb(), rb(), ins, r);
    if (cls >= 6) begin sync(); return; end
    last_aop = a;
    r = base(3'd2); r.srcb = sb;
    if ((cls == 4 && z) || (cls == 5 && !z)) begin r.pc_we = 1'b1; r.pc_src = 2'b01; end
    step(1'b1, rb(), z, ins, r);
    if (cls == 4 || cls == 5) begin sync(); return; end
    if (cls == 2 || cls == 3) begin
      for (int i = 0; i <= mem_wait; i++) begin
        r = base(3'd3); r.iord = 1'b1; r.mem_re = (cls == 2); r.mem_we = (cls == 3);
        if (i == mem_wait && abort_mem) begin
          r = '0; r.st = 3'd3;
          step(1'b0, 1'b0, rb(), ins, r);
          last_aop = 3'b000;
          sync();
          return;
        end
        step(1'b1, (i == mem_wait), rb(), ins, r);
      end
      if (cls == 3) begin sync(); return; end
    end
    r = base(3'd4); r.reg_we = 1'b1; r.reg_dst = (cls == 0); r.mem_to_reg = (cls == 2);
    step(1'b1, rb(), rb(), ins, r);
    sync();
  endtask

  initial begin : main
    int   s;
    rec_t h;
    rst_n = 1'b0; mem_rdy = 1'b1; zero = 1'b0; instr = I_ADD; last_aop = 3'b000;

    h = '0;
    step(1'b0, 1'b1, 1'b0, I_ADD, h);
    step(1'b0, 1'b1, 1'b0, I_ADD, h);
    sync();
    h = hist[hist.size()-1];
    lit("reset_state", 32'(h.st), 0);
    lit("reset_mem_re", 32'(h.mem_re), 0);

    // add after reset release: IF, ID, EX, WB.
    s = hist.size();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    h = hist[s];   lit("rel_if_state", 32'(h.st), 0); lit("rel_if_mem_re", 32'(h.mem_re), 1);
    h = hist[s+1]; lit("add_id_state", 32'(h.st), 1);
    h = hist[s+2]; lit("add_ex_state", 32'(h.st), 2);
    h = hist[s+3]; lit("add_wb_state", 32'(h.st), 4); lit("add_wb_reg_we", 32'(h.reg_we), 1);
    lit("add_wb_reg_dst", 32'(h.reg_dst), 1); lit("add_wb_alu_op", 32'(h.aop), 0);

    // lw with three wait cycles in MEM.
    s = hist.size();
    run_instr(I_LW, 0, 3, 1'b0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      h = hist[s+i];
      lit("lw_mem_state", 32'(h.st), 3); lit("lw_mem_re", 32'(h.mem_re), 1);
      lit("lw_mem_iord", 32'(h.iord), 1);
    end
    h = hist[s+7]; lit("lw_wb_state", 32'(h.st), 4); lit("lw_wb_m2r", 32'(h.mem_to_reg), 1);

    // Branches in both zero polarities.
    s = hist.size(); run_instr(I_BEQ, 0, 0, 1'b1, 1'b0);
    h = hist[s+2]; lit("beq_z1_pc_we", 32'(h.pc_we), 1); lit("beq_z1_pc_src", 32'(h.pc_src), 1);
    s = hist.size(); run_instr(I_BEQ, 0, 0, 1'b0, 1'b0);
    h = hist[s+2]; lit("beq_z0_pc_we", 32'(h.pc_we), 0);
    s = hist.size(); run_instr(I_BNE, 0, 0, 1'b0, 1'b0);
    h = hist[s+2]; lit("bne_z0_pc_we", 32'(h.pc_we), 1); lit("bne_z0_pc_src", 32'(h.pc_src), 1);
    s = hist.size(); run_instr(I_BNE, 0, 0, 1'b1, 1'b0);
    h = hist[s+2]; lit("bne_z1_pc_we", 32'(h.pc_we), 0);

    // Illegal opcode, then a j to observe the return to IF.
    s = hist.size();
    run_instr(I_BADO, 0, 0, 1'b0, 1'b0);
    run_instr(I_J, 0, 0, 1'b0, 1'b0);
    h = hist[s+1]; lit("ill_id_pulse", 32'(h.ill), 1); lit("ill_id_reg_we", 32'(h.reg_we), 0);
    lit("ill_id_mem_we", 32'(h.mem_we), 0);
    h = hist[s+2]; lit("ill_next_state", 32'(h.st), 0); lit("ill_next_pulse", 32'(h.ill), 0);
    h = hist[s+3]; lit("j_id_pc_src", 32'(h.pc_src), 2);

    // Reset during sw MEM wait abandons the write.
    s = hist.size();
    run_instr(I_SW, 1, 2, 1'b0, 1'b1);
    run_instr(I_ORI, 0, 0, 1'b0, 1'b0);
    h = hist[s+6]; lit("sw_rst_mem_we", 32'(h.mem_we), 0);
    h = hist[s+7]; lit("sw_after_rst_state", 32'(h.st), 0); lit("sw_after_rst_mem_we", 32'(h.mem_we), 0);
    h = hist[s+9]; lit("ori_ex_alu_op", 32'(h.aop), 3'b101); lit("ori_ex_srcb", 32'(h.srcb), 2'b10);
    h = hist[s+10]; lit("ori_wb_alu_op_hold", 32'(h.aop), 3'b101);

    s = hist.size();
    run_instr(I_LUI, 2, 0, 1'b0, 1'b0);
    h = hist[s+4]; lit("lui_ex_alu_op", 32'(h.aop), 3'b110); lit("lui_ex_srcb", 32'(h.srcb), 2'b11);

    // Remaining instruction set through the model only.
    run_instr(I_SUB, 0, 0, 1'b0, 1'b0);
    run_instr(I_AND, 1, 0, 1'b0, 1'b0);
    run_instr(I_OR, 0, 0, 1'b0, 1'b0);
    run_instr(I_XOR, 0, 0, 1'b0, 1'b0);
    run_instr(I_ADDI, 0, 0, 1'b0, 1'b0);
    run_instr(I_ANDI, 0, 0, 1'b0, 1'b0);
    run_instr(I_XORI, 0, 0, 1'b0, 1'b0);
    run_instr(I_SW, 0, 1, 1'b0, 1'b0);
    run_instr(I_BADF, 0, 0, 1'b0, 1'b0);
    run_instr(I_LW, 1, 0, 1'b1, 1'b0);

    sync();
    lit("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The port list SHALL be, one per line, name direction width meaning:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- instr  input  32  IR contents, stable from DECODE onward
- zero  input  1  ALU zero flag from current ALU result
- mem_rdy  input  1  memory completes current read/write this cycle
- pc_we  output  1  PC write enable
- pc_src  output  2  00 PC+4, 01 branch target, 10 jump target
- ir_we  output  1  IR write enable
- iord  output  1  memory address select: 0 PC, 1 ALU result register
- mem_re / mem_we  output  1 each  memory read / write request
- reg_we  output  1  register-file write enable
- reg_dst  output  1  write index: 0 rt, 1 rd
- mem_to_reg  output  1  write data: 0 ALU result, 1 memory data
- alu_srcb  output  2  00 reg B, 01 sign-ext imm, 10 zero-ext imm, 11 imm<<16
- alu_op  output  3  000 add, 100 sub, 001 and, 101 or, 010 xor, 110 pass B
- illegal  output  1  one-cycle pulse on unrecognised instruction
- state  output  3  current FSM state, for debug
REQ-002 Reset SHALL be synchronous, active-low on rst_n, sampled on the rising edge of clk.

Function
REQ-003 States SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; all other codes go to IF next cycle.
REQ-004 IF: mem_re=1, iord=0; hold IF while mem_rdy=0; on mem_rdy=1 assert ir_we=1, pc_we=1, pc_src=00 that cycle only and go to ID.
REQ-005 ID: decode instr[31:26]/[5:0]; j (000010) asserts pc_we=1, pc_src=10, then IF; unrecognised opcode or funct pulses illegal=1, no writes, then IF; all others go to EX.
REQ-006 Supported set: R-type funct add 100000, sub 100010, and 100100, or 100101, xor 100110; addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
REQ-007 EX alu_op/alu_srcb: R-type per funct with srcb=00; addi add/01; andi, ori, xori and/or/xor with 10; lui pass B/11; lw, sw add/01; beq, bne sub/00.
REQ-008 EX next state: R-type and immediate ops to WB; lw, sw to MEM; beq, bne to IF.
REQ-009 Branch in EX: pc_we=1, pc_src=01 iff (beq and zero=1) or (bne and zero=0); else pc_we=0.
REQ-010 MEM: iord=1; mem_re=1 for lw, mem_we=1 for sw; hold while mem_rdy=0; on mem_rdy=1 lw goes to WB, sw to IF.
REQ-011 WB: reg_we=1 for exactly one cycle; reg_dst=1 for R-type, else 0; mem_to_reg=1 for lw only; next state IF.
REQ-012 Outputs SHALL be combinational from state and instr (Moore plus instr decode); every enable not listed for a state is 0.
REQ-013 Latency with mem_rdy always 1: j 2, beq/bne 3, sw 4, R/I 4, lw 5 cycles per instruction.
REQ-014 mem_rdy outside IF and MEM SHALL be ignored; zero outside EX SHALL be ignored.
REQ-015 alu_op SHALL hold last EX value outside EX; no other output has memory.

Reset
REQ-016 While rst_n=0 at an edge: state<=IF; all enables, illegal, pc_src, alu_srcb = 0; alu_op = 000.
REQ-017 Reset in any state, including mid-handshake in IF or MEM, SHALL abandon the access; mem_re/mem_we drop the cycle rst_n is low.
REQ-018 First cycle after release SHALL be IF with mem_re=1.

Structure
REQ-019 Package cpu_pkg SHALL hold state encodings, alu_op codes, alu_srcb/pc_src codes, opcode and funct constants; the ALU shares the alu_op codes.
REQ-020 Instruction classification (class, alu_op, alu_srcb, legal) SHALL be a combinational sub-module mc_decode; mc_ctrl holds only the FSM.

Verification
REQ-021 Bench SHALL cover:
- rst_n=0 2 cycles then 1, mem_rdy=1, instr=add (0x00221820) -> states IF,ID,EX,WB; alu_op=000, reg_we=1 and reg_dst=1 in cycle 4.
- lw 0x8C220004 with mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, mem_re=1, iord=1 throughout, then WB with mem_to_reg=1.
- beq 0x10220003, zero=1 -> pc_we=1, pc_src=01 in EX; repeat with zero=0 -> pc_we=0; bne inverse.
- opcode 0x3F -> illegal=1 one cycle in ID, no reg_we/mem_we, next state IF.
- rst_n=0 during MEM of sw with mem_rdy=0 -> next cycle state=IF, mem_we=0, no write.
- ori 0x34220F0F -> EX alu_op=101, alu_srcb=10; lui 0x3C011234 -> alu_op=110, alu_srcb=11.
